snn_axi_lite_master: RTL and testbench

- Single-outstanding AXI4-Lite master (initiator) for the SNN accelerator's AXI-Lite config/memory slave.
- Lets an on-chip sequencer (test driver, batch loader, soft controller) issue register and memory-window reads/writes without a processor: loading weights and spike patterns, pulsing ctrl, polling done, reading output spike counts.
- Accepts one command on a valid/ready port, runs the full AXI-Lite transaction, and returns one response on a valid/ready port.
- Includes a per-transaction timeout so a hung slave cannot deadlock the sequencer.

---
 rtl/snn_axi_pkg.sv | 17 +
 rtl/snn_axi_lite_master_counter.sv | 20 ++
 rtl/snn_axi_lite_master.sv | 214 +++++++++++++++++++++
 tb/tb_snn_axi_lite_master.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_axi_pkg.sv
// Shared AXI4-Lite response codes and master state encoding for the SNN
// accelerator's sequencer-side AXI-Lite initiator.
package snn_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        RESP
    } state_t;

endpackage

// File: rtl/snn_axi_lite_master_counter.sv
// Saturating up-counter with synchronous clear; used as the per-transaction
// timeout timer of the AXI-Lite master.
module snn_axi_lite_master_counter #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    output logic [DATA_WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + DATA_WIDTH'(1);
        end
    end

endmodule

// File: rtl/snn_axi_lite_master.sv
// Single-outstanding AXI4-Lite master: one command in, one full AXI-Lite
// transaction, one response out, with hung-slave timeout recovery.
module snn_axi_lite_master
    import snn_axi_pkg::*;
#(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 16,
    parameter int TIMEOUT_CYCLES     = 1024,
    parameter int TIMEOUT_BITS       = 16
) (
    input  logic                            clk,
    input  logic                            rst,

    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,

    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                      rsp_resp,
    output logic                            rsp_timeout,
    output logic                            busy,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam int STRB_W = C_M_AXI_DATA_WIDTH / 8;
    localparam logic [TIMEOUT_BITS-1:0] TO_LIMIT = TIMEOUT_BITS'(TIMEOUT_CYCLES);

    state_t state, state_d;

    logic                          accept;
    logic                          active;
    logic                          b_hs;
    logic                          r_hs;
    logic                          to_fire;
    logic [TIMEOUT_BITS-1:0]       to_count;

    logic                          cmd_ready_d;
    logic                          rsp_valid_d;
    logic [C_M_AXI_DATA_WIDTH-1:0] rsp_rdata_d;
    logic [1:0]                    rsp_resp_d;
    logic                          rsp_timeout_d;
    logic                          busy_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0] awaddr_d;
    logic                          awvalid_d;
    logic [C_M_AXI_DATA_WIDTH-1:0] wdata_d;
    logic [STRB_W-1:0]             wstrb_d;
    logic                          wvalid_d;
    logic                          bready_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0] araddr_d;
    logic                          arvalid_d;
    logic                          rready_d;

    assign accept = cmd_valid && cmd_ready;
    assign active = (state == WRITE) || (state == READ);
    assign b_hs   = M_AXI_BVALID && M_AXI_BREADY;
    assign r_hs   = M_AXI_RVALID && M_AXI_RREADY;
    assign to_fire = (TIMEOUT_CYCLES != 0) && active && (to_count == TO_LIMIT);

    // Timer restarts on every accept so each transaction gets a full budget.
    snn_axi_lite_master_counter #(
        .DATA_WIDTH(TIMEOUT_BITS)
    ) u_timeout (
        .clk  (clk),
        .rst  (rst || accept),
        .en   (active),
        .count(to_count)
    );

    always_comb begin
        state_d       = state;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata;
        rsp_resp_d    = rsp_resp;
        rsp_timeout_d = rsp_timeout;
        awaddr_d      = M_AXI_AWADDR;
        awvalid_d     = M_AXI_AWVALID;
        wdata_d       = M_AXI_WDATA;
        wstrb_d       = M_AXI_WSTRB;
        wvalid_d      = M_AXI_WVALID;
        araddr_d      = M_AXI_ARADDR;
        arvalid_d     = M_AXI_ARVALID;

        case (state)
            IDLE: begin
                if (accept) begin
                    if (cmd_write) begin
                        state_d   = WRITE;
                        awaddr_d  = cmd_addr;
                        wdata_d   = cmd_wdata;
                        wstrb_d   = cmd_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = READ;
                        araddr_d  = cmd_addr;
                        arvalid_d = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (M_AXI_AWVALID && M_AXI_AWREADY) awvalid_d = 1'b0;
                if (M_AXI_WVALID && M_AXI_WREADY)   wvalid_d  = 1'b0;
                // A genuine response takes priority over a simultaneous timeout.
                if (b_hs) begin
                    state_d       = RESP;
                    rsp_rdata_d   = '0;
                    rsp_resp_d    = M_AXI_BRESP;
                    rsp_timeout_d = 1'b0;
                end else if (to_fire) begin
                    state_d       = RESP;
                    rsp_rdata_d   = '0;
                    rsp_resp_d    = RESP_SLVERR;
                    rsp_timeout_d = 1'b1;
                end
            end
            READ: begin
                if (M_AXI_ARVALID && M_AXI_ARREADY) arvalid_d = 1'b0;
                if (r_hs) begin
                    state_d       = RESP;
                    rsp_rdata_d   = M_AXI_RDATA;
                    rsp_resp_d    = M_AXI_RRESP;
                    rsp_timeout_d = 1'b0;
                end else if (to_fire) begin
                    state_d       = RESP;
                    rsp_rdata_d   = '0;
                    rsp_resp_d    = RESP_SLVERR;
                    rsp_timeout_d = 1'b1;
                end
            end
            RESP: begin
                if (rsp_valid && rsp_ready) begin
                    state_d = IDLE;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Leaving a channel state (normally or by timeout) drops its handshakes.
        if (state_d != WRITE) begin
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
        end
        if (state_d != READ) begin
            arvalid_d = 1'b0;
        end
        bready_d    = (state_d == WRITE) && !awvalid_d && !wvalid_d;
        rready_d    = (state_d == READ) && !arvalid_d;
        cmd_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cmd_ready     <= 1'b1;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= RESP_OKAY;
            rsp_timeout   <= 1'b0;
            busy          <= 1'b0;
            M_AXI_AWADDR  <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WDATA   <= '0;
            M_AXI_WSTRB   <= '0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARADDR  <= '0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
        end else begin
            state         <= state_d;
            cmd_ready     <= cmd_ready_d;
            rsp_valid     <= rsp_valid_d;
            rsp_rdata     <= rsp_rdata_d;
            rsp_resp      <= rsp_resp_d;
            rsp_timeout   <= rsp_timeout_d;
            busy          <= busy_d;
            M_AXI_AWADDR  <= awaddr_d;
            M_AXI_AWVALID <= awvalid_d;
            M_AXI_WDATA   <= wdata_d;
            M_AXI_WSTRB   <= wstrb_d;
            M_AXI_WVALID  <= wvalid_d;
            M_AXI_BREADY  <= bready_d;
            M_AXI_ARADDR  <= araddr_d;
            M_AXI_ARVALID <= arvalid_d;
            M_AXI_RREADY  <= rready_d;
        end
    end

endmodule

// File: tb/tb_snn_axi_lite_master.sv
// Directed bench for snn_axi_lite_master with a delay-configurable AXI-Lite
// slave model and a response scoreboard.
module tb_snn_axi_lite_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [15:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_timeout, busy;
    logic [15:0] M_AXI_AWADDR, M_AXI_ARADDR;
    logic        M_AXI_AWVALID, M_AXI_AWREADY;
    logic [31:0] M_AXI_WDATA, M_AXI_RDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_WVALID, M_AXI_WREADY;
    logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
    logic        M_AXI_BVALID, M_AXI_BREADY;
    logic        M_AXI_ARVALID, M_AXI_ARREADY;
    logic        M_AXI_RVALID, M_AXI_RREADY;

    snn_axi_lite_master #(
        .C_M_AXI_DATA_WIDTH(32),
        .C_M_AXI_ADDR_WIDTH(16),
        .TIMEOUT_CYCLES    (16),
        .TIMEOUT_BITS      (16)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .busy(busy),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
        .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
        .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID),
        .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    always #5 clk = ~clk;

    // Slave model: READY after N cycles of VALID (N<0 = never); B/R after N cycles.
    int          aw_dly, w_dly, ar_dly, b_dly, r_dly;
    logic [1:0]  b_resp_cfg, r_resp_cfg;
    logic [31:0] r_data_cfg;
    logic        slv_clr;
    int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    logic        aw_got, w_got, ar_got;

    assign M_AXI_AWREADY = M_AXI_AWVALID && (aw_dly >= 0) && (aw_cnt >= aw_dly);
    assign M_AXI_WREADY  = M_AXI_WVALID && (w_dly >= 0) && (w_cnt >= w_dly);
    assign M_AXI_ARREADY = M_AXI_ARVALID && (ar_dly >= 0) && (ar_cnt >= ar_dly);
    assign M_AXI_BVALID  = aw_got && w_got && (b_cnt >= b_dly);
    assign M_AXI_BRESP   = b_resp_cfg;
    assign M_AXI_RVALID  = ar_got && (r_cnt >= r_dly);
    assign M_AXI_RDATA   = M_AXI_RVALID ? r_data_cfg : 32'h0;
    assign M_AXI_RRESP   = r_resp_cfg;

    always @(posedge clk) begin
        if (rst || slv_clr) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
        end else begin
            aw_cnt <= (M_AXI_AWVALID && !M_AXI_AWREADY) ? aw_cnt + 1 : 0;
            w_cnt  <= (M_AXI_WVALID && !M_AXI_WREADY) ? w_cnt + 1 : 0;
            ar_cnt <= (M_AXI_ARVALID && !M_AXI_ARREADY) ? ar_cnt + 1 : 0;
            if (M_AXI_AWVALID && M_AXI_AWREADY) aw_got <= 1'b1;
            if (M_AXI_WVALID && M_AXI_WREADY) w_got <= 1'b1;
            if (M_AXI_BVALID && M_AXI_BREADY) begin
                aw_got <= 1'b0; w_got <= 1'b0; b_cnt <= 0;
            end else if (aw_got && w_got && !M_AXI_BVALID) begin
                b_cnt <= b_cnt + 1;
            end
            if (M_AXI_ARVALID && M_AXI_ARREADY) ar_got <= 1'b1;
            if (M_AXI_RVALID && M_AXI_RREADY) begin
                ar_got <= 1'b0; r_cnt <= 0;
            end else if (ar_got && !M_AXI_RVALID) begin
                r_cnt <= r_cnt + 1;
            end
        end
    end

    typedef struct packed {
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        to;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Per-transaction observations, cycle 1 = first cycle after the accept edge.
    int          lat, aw_last, w_last, ar_last, br_first, rr_first;
    logic [15:0] awaddr1, araddr1;
    logic [31:0] wdata1;
    logic [3:0]  wstrb1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_slave(input int awd, input int wd, input int ard, input int bd,
                             input int rd, input logic [1:0] br, input logic [1:0] rr,
                             input logic [31:0] rdat);
        aw_dly = awd; w_dly = wd; ar_dly = ard; b_dly = bd; r_dly = rd;
        b_resp_cfg = br; r_resp_cfg = rr; r_data_cfg = rdat;
    endtask

    task automatic issue(input logic wr, input logic [15:0] a, input logic [31:0] wd,
                         input logic [3:0] st);
        int n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready_before_issue", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd; cmd_wstrb = st;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic txn_finish(input string tag, input int hold);
        exp_t        e;
        logic [31:0] d;
        logic [1:0]  r;
        logic        t;
        int          cyc = 1;
        aw_last = 0; w_last = 0; ar_last = 0; br_first = 0; rr_first = 0;
        awaddr1 = M_AXI_AWADDR; wdata1 = M_AXI_WDATA; wstrb1 = M_AXI_WSTRB; araddr1 = M_AXI_ARADDR;
        while (!rsp_valid && cyc < 100) begin
            if (M_AXI_AWVALID) aw_last = cyc;
            if (M_AXI_WVALID) w_last = cyc;
            if (M_AXI_ARVALID) ar_last = cyc;
            if (M_AXI_BREADY && br_first == 0) br_first = cyc;
            if (M_AXI_RREADY && rr_first == 0) rr_first = cyc;
            @(negedge clk);
            cyc++;
        end
        lat = cyc;
        cmd_valid = 1'b0;
        chk({tag, " rsp_valid_seen"}, 64'(rsp_valid), 64'd1);
        chk({tag, " chans_idle_at_rsp"},
            64'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}), 64'd0);
        d = rsp_rdata; r = rsp_resp; t = rsp_timeout;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, " hold_stable"}, 64'({rsp_valid, cmd_ready, rsp_rdata, rsp_resp, rsp_timeout}),
                64'({1'b1, 1'b0, d, r, t}));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, " after_rsp_hs"}, 64'({rsp_valid, cmd_ready, busy}), 64'(3'b010));
        chk({tag, " sb_nonempty"}, 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, " rdata"}, 64'(d), 64'(e.rdata));
            chk({tag, " resp"}, 64'(r), 64'(e.resp));
            chk({tag, " timeout"}, 64'(t), 64'(e.to));
        end
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        cmd_wstrb = '0; rsp_ready = 1'b0; slv_clr = 1'b0;
        set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_ctrl", 64'({cmd_ready, rsp_valid, busy, M_AXI_AWVALID, M_AXI_WVALID,
                               M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY, rsp_timeout}),
            64'(9'b1_0000_0000));
        chk("reset_rsp_data", 64'({rsp_rdata, rsp_resp}), 64'd0);

        // Zero-wait write
        set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
        sb.push_back('{32'h0, 2'b00, 1'b0});
        issue(1'b1, 16'h0004, 32'h0000_0001, 4'hF);
        chk("wr0 busy", 64'(busy), 64'd1);
        txn_finish("wr0", 0);
        chk("wr0 aw_fields", 64'({awaddr1, wdata1, wstrb1}), 64'({16'h0004, 32'h1, 4'hF}));
        chk("wr0 timing", 64'({8'(aw_last), 8'(w_last), 8'(br_first), 8'(lat)}),
            64'({8'd1, 8'd1, 8'd2, 8'd4}));

        // Write with AWREADY after 1 cycle, WREADY after 5; stray cmd held during it
        set_slave(1, 5, 0, 0, 0, 2'b00, 2'b00, 32'h0);
        sb.push_back('{32'h0, 2'b00, 1'b0});
        issue(1'b1, 16'h0100, 32'hA5A5_0F0F, 4'h5);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'hBEEF;
        txn_finish("wr1", 0);
        chk("wr1 timing", 64'({8'(aw_last), 8'(w_last), 8'(br_first), 8'(lat), 8'(ar_last)}),
            64'({8'd2, 8'd6, 8'd7, 8'd9, 8'd0}));
        chk("wr1 wdata", 64'({wdata1, wstrb1}), 64'({32'hA5A5_0F0F, 4'h5}));
        @(negedge clk);
        chk("wr1 single_rsp", 64'({rsp_valid, busy}), 64'd0);

        // Read with ARREADY after 2 cycles, RVALID 3 cycles after AR handshake
        set_slave(0, 0, 2, 0, 3, 2'b00, 2'b00, 32'hDEAD_BEEF);
        sb.push_back('{32'hDEAD_BEEF, 2'b00, 1'b0});
        issue(1'b0, 16'h0010, 32'h0, 4'h0);
        txn_finish("rd0", 0);
        chk("rd0 araddr", 64'(araddr1), 64'(16'h0010));
        chk("rd0 timing", 64'({8'(ar_last), 8'(rr_first), 8'(lat)}), 64'({8'd3, 8'd4, 8'd9}));

        // Read returning SLVERR, response back-pressured for 4 cycles
        set_slave(0, 0, 0, 0, 0, 2'b00, 2'b10, 32'h1234_5678);
        sb.push_back('{32'h1234_5678, 2'b10, 1'b0});
        issue(1'b0, 16'h0020, 32'h0, 4'h0);
        txn_finish("rd1", 4);
        chk("rd1 latency", 64'(lat), 64'd4);

        // Hung AW channel: timeout after 16 cycles
        set_slave(-1, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
        sb.push_back('{32'h0, 2'b10, 1'b1});
        issue(1'b1, 16'h0040, 32'h5555_AAAA, 4'hF);
        txn_finish("wr_to", 0);
        chk("wr_to timing", 64'({8'(aw_last), 8'(w_last), 8'(br_first), 8'(lat)}),
            64'({8'd17, 8'd1, 8'd0, 8'd19}));
        slv_clr = 1'b1;
        @(negedge clk);
        slv_clr = 1'b0;

        // Read after timeout recovery
        set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'hCAFE_F00D);
        sb.push_back('{32'hCAFE_F00D, 2'b00, 1'b0});
        issue(1'b0, 16'h0044, 32'h0, 4'h0);
        txn_finish("rd_after_to", 0);
        chk("rd_after_to latency", 64'(lat), 64'd4);

        // Reset while ARVALID is held by a never-ready slave
        set_slave(0, 0, -1, 0, 0, 2'b00, 2'b00, 32'h0);
        issue(1'b0, 16'h0080, 32'h0, 4'h0);
        chk("rst_mid_read arvalid_before", 64'({M_AXI_ARVALID, busy}), 64'(2'b11));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_read outs", 64'({M_AXI_ARVALID, M_AXI_RREADY, rsp_valid, cmd_ready, busy}),
            64'(5'b00010));

        // Write after reset, EXOKAY passes through
        set_slave(0, 0, 0, 0, 0, 2'b01, 2'b00, 32'h0);
        sb.push_back('{32'h0, 2'b01, 1'b0});
        issue(1'b1, 16'h0200, 32'h0000_BEEF, 4'h3);
        txn_finish("wr_after_rst", 0);
        chk("wr_after_rst fields", 64'({awaddr1, wstrb1, 8'(lat)}), 64'({16'h0200, 4'h3, 8'd4}));
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
